// File: rtl/present_job_scheduler.sv
// present_job_scheduler: round-robin front end that feeds two requesters' jobs
// through one PRESENT-80 core, with a timeout against a hung core.
module present_job_scheduler #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [63:0]  req_msg0,
   input  logic [63:0]  req_msg1,
   input  logic [79:0]  req_key0,
   input  logic [79:0]  req_key1,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [63:0]  res_enc,
   output logic         res_id,
   output logic         res_err,
   output logic [15:0]  job_count,
   output logic         core_rst,
   output logic [63:0]  core_msg,
   output logic [79:0]  core_key,
   input  logic         core_ready,
   input  logic [63:0]  core_enc
);
   typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;
   state_t             state_q, state_d;
   logic               last_q, last_d, id_q, id_d, err_q, err_d;
   logic [63:0]        msg_q, msg_d, enc_q, enc_d;
   logic [79:0]        key_q, key_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        jobs_q, jobs_d;
   logic               g, hit, expire;
   always_comb begin
      g         = &req_valid ? ~last_q : req_valid[1];
      req_ready = (state_q == IDLE && !rst && |req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
      // a ready seen in the first BUSY cycle may be left over from the previous job
      hit       = core_ready && cnt_q != '0;
      expire    = cnt_q == CNT_W'(TIMEOUT - 1);
      state_d   = state_q;
      last_d    = last_q;
      id_d      = id_q;
      err_d     = err_q;
      msg_d     = msg_q;
      key_d     = key_q;
      enc_d     = enc_q;
      cnt_d     = cnt_q;
      jobs_d    = jobs_q;
      case (state_q)
         IDLE: if (|req_ready) begin
            msg_d   = g ? req_msg1 : req_msg0;
            key_d   = g ? req_key1 : req_key0;
            id_d    = g;
            last_d  = g;
            state_d = LOAD;
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = BUSY;
         end
         BUSY: begin
            cnt_d   = (hit || expire) ? cnt_q : cnt_q + CNT_W'(1);
            enc_d   = hit ? core_enc : expire ? 64'd0 : enc_q;
            err_d   = hit ? 1'b0 : expire ? 1'b1 : err_q;
            state_d = (hit || expire) ? DONE : BUSY;
         end
         DONE: if (res_ready) begin
            jobs_d  = jobs_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         msg_q   <= '0;
         key_q   <= '0;
         enc_q   <= '0;
         cnt_q   <= '0;
         jobs_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         err_q   <= err_d;
         msg_q   <= msg_d;
         key_q   <= key_d;
         enc_q   <= enc_d;
         cnt_q   <= cnt_d;
         jobs_q  <= jobs_d;
      end
   end
   assign res_valid = state_q == DONE;
   assign res_enc   = enc_q;
   assign res_id    = id_q;
   assign res_err   = err_q;
   assign job_count = jobs_q;
   assign core_rst  = rst | (state_q == LOAD);
   assign core_msg  = msg_q;
   assign core_key  = key_q;
endmodule

// File: doc/present_job_scheduler.md
# present_job_scheduler

Two-requester scheduler that shares one `present_encrypt` core. It arbitrates between two job sources with round-robin priority and latches the winning message and key. It sequences the core through a one-cycle load pulse on the core's `rst` input, waits for the core's `ready`, and returns the ciphertext tagged with the requester ID. It sits between the message sources (including the Hamming-protected input path) and the single PRESENT-80 encryption core, and guards against a hung core with a timeout.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum number of BUSY cycles to wait for `core_ready` before aborting the job.
- `CNT_W`, 7: width of the BUSY cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  bit i set means requester i has a job.
- `req_ready`  out  2  bit i set means the scheduler accepts requester i's job this cycle.
- `req_msg0`, `req_msg1`  in  64  plaintext from requester 0 and requester 1.
- `req_key0`, `req_key1`  in  80  key from requester 0 and requester 1.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_enc`  out  64  ciphertext; 0 on error.
- `res_id`  out  1  requester that owns the result.
- `res_err`  out  1  job aborted by timeout.
- `job_count`  out  16  number of completed jobs (good or error); wraps modulo 2^16.
- `core_rst`  out  1  drives the core's `rst` (load/restart).
- `core_msg`  out  64  drives the core's `msg`.
- `core_key`  out  80  drives the core's `key`.
- `core_ready`  in  1  from the core's `ready`.
- `core_enc`  in  64  from the core's `enc`.

## Operation
- FSM states: IDLE, LOAD, BUSY, DONE.
- **Arbitration.** A 1-bit pointer `last` records the last grant.
  - In IDLE, the grant goes to the single valid requester.
  - If both requesters are valid, the grant goes to `~last`.
  - `req_ready[g]` = (state==IDLE) && `req_valid[g]`; the other bit is 0. In every non-IDLE state both bits are 0.
- **IDLE.** On a handshake (`req_valid[g]` & `req_ready[g]`), register the msg/key of g into `msg_r`/`key_r`, set `id_r`=g and `last`=g, then go to LOAD.
- **LOAD.** Hold for exactly 1 cycle with `core_rst`=1. Clear the counter `cnt`. Go to BUSY.
- **BUSY.** Increment `cnt` every cycle.
  - `core_ready` is ignored while `cnt`==0, which masks a stale ready from the previous job.
  - If `core_ready`=1 with `cnt`≥1: capture `core_enc` into `res_enc`, set `res_err`=0, go to DONE.
  - Else if `cnt`==TIMEOUT-1: set `res_enc`=0 and `res_err`=1, go to DONE.
- **DONE.** `res_valid`=1, with `res_enc`, `res_id` and `res_err` stable. Stay in DONE until `res_ready`=1. On that cycle, increment `job_count` and go to IDLE.
- `core_msg`=`msg_r` and `core_key`=`key_r` at all times, so they are stable through LOAD and BUSY.
- `core_rst` = `rst` | (state==LOAD). A system reset therefore also resets the core.
- **Reset values.**
  - state=IDLE, `last`=1 (requester 0 wins the first tie).
  - `req_ready`=0 and `res_valid`=0.
  - `res_enc`=0, `res_id`=0, `res_err`=0.
  - `job_count`=0, `msg_r`=0, `key_r`=0, `core_rst`=1.

## Timing
- **Handshake cycles.** Accept at cycle T, LOAD at T+1, first BUSY cycle at T+2.
- **Result latency.** If the core asserts ready for the first time at BUSY cycle k (k≥1), `res_valid` rises at T+3+k.
- **Throughput.** The next accept can happen no earlier than the cycle after the `res_ready` handshake. There is no overlap, because the core is single-job.
- **Reset mid-job.** Reset in any state returns to IDLE on the next edge. The in-flight job is dropped and `job_count` is not incremented.
- **Input changes during a job.** Changes on `req_msg*`/`req_key*` after the accept have no effect.
- **Backpressure.** While `res_ready`=0, DONE holds indefinitely and outputs stay stable.
- **Counter width.** `cnt` never exceeds TIMEOUT-1. `job_count` wraps from 0xFFFF to 0x0000.

## Test plan
- **Single job, zero vectors.** Requester 0, msg 0, key 0 → `res_enc`=5579C1387B228445, `res_id`=0, `res_err`=0, `job_count`=1.
- **Round-robin sequence.** Both valid continuously. Requester 0 has msg 0, key all-F; requester 1 has msg all-F, key 0. Expected results in order:
  - id0 E72C46C0F5945049,
  - then id1 A112FFC72F68417B,
  - then id0 again.
- **Backpressure.** Requester 1 sends msg all-F, key all-F. Hold `res_ready`=0 for 20 cycles → `res_valid` stays 1 with 3333DCD3213210D2 stable and `req_ready`=00. Releasing `res_ready` returns the FSM to IDLE on the next edge.
- **Timeout.** Tie `core_ready`=0 → `res_valid` rises TIMEOUT cycles after BUSY entry, with `res_err`=1 and `res_enc`=0.
- **Stale ready.** Hold `core_ready`=1 through LOAD and the first BUSY cycle → no capture at `cnt`=0. The result is taken at the first ready seen with `cnt`≥1.
- **Reset mid-BUSY.** Assert `rst` mid-BUSY → IDLE with all outputs at reset values and `core_rst`=1 during reset. The next job completes correctly with `job_count`=1.
